// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Contents: the arbiter FSM state encoding and the default byte width.
package uart_arb_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the arbiter and the UART sender.
// Ports (signals):
//   req_valid   producer i holds a byte
//   req_data    packed bytes, producer i at [i*DATA_W +: DATA_W]
//   req_ready   one-hot accept back to the producers
//   tx_data     byte presented to the sender
//   tx_start    one-cycle start strobe to the sender
//   tx_busy     sender is shifting a frame
//   grant_id    index of the last accepted producer
//   timeout_err one-cycle pulse when the sender never went busy
// Modports: master = arbiter side, slave = producers/sender side.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEFAULT
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ready;
    logic [DATA_W-1:0]        tx_data;
    logic                     tx_start;
    logic                     tx_busy;
    logic [$clog2(N_REQ)-1:0] grant_id;
    logic                     timeout_err;

    modport master (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_data, tx_start, grant_id, timeout_err
    );

    modport slave (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_data, tx_start, grant_id, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  highest-priority index for this search
//   gnt  out N   one-hot winner (zero when req is zero)
//   idx  out IW  index of the winner (don't-care when gnt is zero)
// The request vector is rotated down by ptr using a double-width shift,
// the lowest set bit is found, and the offset is folded back modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic [N-1:0]  rot_s;
    logic [IW-1:0] off_s;
    logic          found_s;
    logic [IW:0]   sum_s;

    // Rotate, priority-encode from the pointer, and map back to an absolute index.
    always_comb begin
        rot_s   = N'({req, req} >> ptr);
        found_s = 1'b0;
        off_s   = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (!found_s && rot_s[i]) begin
                found_s = 1'b1;
                off_s   = IW'(i);
            end else begin
                found_s = found_s;
            end
        end
        // ptr and off_s are both below N, so one conditional subtract wraps.
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= (IW+1)'(N)) begin
            idx = IW'(sum_s - (IW+1)'(N));
        end else begin
            idx = sum_s[IW-1:0];
        end
        if (found_s) begin
            gnt = {{(N-1){1'b0}}, 1'b1} << idx;
        end else begin
            gnt = {N{1'b0}};
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART sender between N_REQ producers.
// Ports:
//   CLK    in  system clock, rising edge
//   RST_N  in  asynchronous active-low reset
//   bus    master modport of uart_tx_arbiter_if (producer handshake,
//          sender data/start/busy, grant_id, timeout_err)
// Exactly one byte is in flight: after a grant the FSM strobes tx_start,
// waits for the sender to go busy (bounded by BUSY_TIMEOUT) and then for
// it to finish before the next grant is offered.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int DATA_W       = DATA_W_DEFAULT,
    parameter  int BUSY_TIMEOUT = 16,
    localparam int IW           = $clog2(N_REQ),
    localparam int CW           = $clog2(BUSY_TIMEOUT + 1)
) (
    input logic             CLK,
    input logic             RST_N,
    uart_tx_arbiter_if.master bus
);
    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic              tx_start_q, tx_start_d;
    logic              timeout_err_q, timeout_err_d;

    logic [N_REQ-1:0]  pick_gnt_s;
    logic [IW-1:0]     pick_idx_s;
    logic [N_REQ-1:0]  grant_s;
    logic              xfer_s;
    logic [DATA_W-1:0] sel_data_s;

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .req (bus.req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    // Offer a grant only in IDLE with the sender quiet; a busy sender left
    // over from before reset holds off all producers.
    always_comb begin
        if ((state_q == IDLE) && !bus.tx_busy) begin
            grant_s = pick_gnt_s;
        end else begin
            grant_s = {N_REQ{1'b0}};
        end
        xfer_s = |(grant_s & bus.req_valid);
    end

    // Select the winning producer's byte.
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx_s == IW'(i)) begin
                sel_data_s = bus.req_data[i*DATA_W +: DATA_W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Next-state and registered-output logic of the transmit FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        grant_id_d    = grant_id_q;
        tx_start_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer_s) begin
                    tx_data_d  = sel_data_s;
                    grant_id_d = pick_idx_s;
                    if (pick_idx_s == IW'(N_REQ - 1)) begin
                        ptr_d = {IW{1'b0}};
                    end else begin
                        ptr_d = pick_idx_s + IW'(1'b1);
                    end
                    tx_start_d = 1'b1;
                    state_d    = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_d   = {CW{1'b0}};
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    // Sender never acknowledged: drop the byte, no retry.
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1'b1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            ptr_q         <= {IW{1'b0}};
            cnt_q         <= {CW{1'b0}};
            tx_data_q     <= {DATA_W{1'b0}};
            grant_id_q    <= {IW{1'b0}};
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            grant_id_q    <= grant_id_d;
            tx_start_q    <= tx_start_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.req_ready   = grant_s;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (N_REQ=4, DATA_W=8, BUSY_TIMEOUT=16).
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
module tb_uart_tx_arbiter;
    logic CLK;
    logic RST_N;
    int   passed;
    int   total;

    uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(16)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Sender stand-in used from the START cycle: goes busy next cycle for
    // dur cycles, then returns; ends on the first IDLE cycle.
    task automatic sender_frame(input int dur);
        @(negedge CLK);
        bus.tx_busy = 1'b1;
        repeat (dur) @(negedge CLK);
        bus.tx_busy = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        @(negedge CLK);
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want %b", bus.req_ready, 4'b0000); else passed++;
        total++; if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want %b", bus.tx_start, 1'b0); else passed++;
        total++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want %h", bus.tx_data, 8'h00); else passed++;
        total++; if (bus.grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want %0d", bus.grant_id, 0); else passed++;
        total++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want %b", bus.timeout_err, 1'b0); else passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_fairness;
        logic [3:0] exp_gnt;
        logic [7:0] exp_data;
        bus.req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_gnt  = 4'b0001 << (k % 4);
            exp_data = 8'hA0 + 8'(k % 4);
            #1;
            total++; if (bus.req_ready !== exp_gnt) $display("FAIL fair_ready[%0d]: got %b want %b", k, bus.req_ready, exp_gnt); else passed++;
            @(negedge CLK);
            #1;
            total++; if (bus.tx_start !== 1'b1) $display("FAIL fair_start[%0d]: got %b want %b", k, bus.tx_start, 1'b1); else passed++;
            total++; if (bus.grant_id !== 2'(k % 4)) $display("FAIL fair_grant_id[%0d]: got %0d want %0d", k, bus.grant_id, k % 4); else passed++;
            total++; if (bus.tx_data !== exp_data) $display("FAIL fair_data[%0d]: got %h want %h", k, bus.tx_data, exp_data); else passed++;
            sender_frame(1);
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_single;
        // cycle 0
        bus.req_data  = {8'h44, 8'h43, 8'h42, 8'h41};
        bus.req_valid = 4'b0001;
        #1;
        total++; if (bus.req_ready !== 4'b0001) $display("FAIL single_ready_c0: got %b want %b", bus.req_ready, 4'b0001); else passed++;
        total++; if (bus.tx_start !== 1'b0) $display("FAIL single_start_c0: got %b want %b", bus.tx_start, 1'b0); else passed++;
        // cycle 1
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.tx_start !== 1'b1) $display("FAIL single_start_c1: got %b want %b", bus.tx_start, 1'b1); else passed++;
        total++; if (bus.tx_data !== 8'h41) $display("FAIL single_data: got %h want %h", bus.tx_data, 8'h41); else passed++;
        total++; if (bus.grant_id !== 2'd0) $display("FAIL single_grant_id: got %0d want %0d", bus.grant_id, 0); else passed++;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL single_ready_c1: got %b want %b", bus.req_ready, 4'b0000); else passed++;
        // cycle 2
        @(negedge CLK);
        #1;
        total++; if (bus.tx_start !== 1'b0) $display("FAIL single_start_c2: got %b want %b", bus.tx_start, 1'b0); else passed++;
        // cycle 3: busy rises for cycles 3..12; a second producer waits
        @(negedge CLK);
        bus.tx_busy   = 1'b1;
        bus.req_valid = 4'b0010;
        repeat (5) @(negedge CLK);
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL single_ready_busy: got %b want %b", bus.req_ready, 4'b0000); else passed++;
        repeat (4) @(negedge CLK);
        // cycle 13: busy sampled low at the end of this cycle
        @(negedge CLK);
        bus.tx_busy = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL single_no_early_grant: got %b want %b", bus.req_ready, 4'b0000); else passed++;
        // cycle 14
        @(negedge CLK);
        #1;
        total++; if (bus.req_ready !== 4'b0010) $display("FAIL single_next_grant: got %b want %b", bus.req_ready, 4'b0010); else passed++;
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.tx_data !== 8'h42) $display("FAIL single_next_data: got %h want %h", bus.tx_data, 8'h42); else passed++;
        sender_frame(2);
    endtask

    task automatic test_wrap;
        // pointer sits at 2; only requester 1 is valid
        bus.req_data  = {8'h00, 8'h00, 8'h5A, 8'h00};
        bus.req_valid = 4'b0010;
        #1;
        total++; if (bus.req_ready !== 4'b0010) $display("FAIL wrap_ready: got %b want %b", bus.req_ready, 4'b0010); else passed++;
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.grant_id !== 2'd1) $display("FAIL wrap_grant_id: got %0d want %0d", bus.grant_id, 1); else passed++;
        total++; if (bus.tx_data !== 8'h5A) $display("FAIL wrap_data: got %h want %h", bus.tx_data, 8'h5A); else passed++;
        sender_frame(1);
        bus.req_data  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
        bus.req_valid = 4'b1111;
        #1;
        total++; if (bus.req_ready !== 4'b0100) $display("FAIL wrap_ptr_next: got %b want %b", bus.req_ready, 4'b0100); else passed++;
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.tx_data !== 8'hD2) $display("FAIL wrap_next_data: got %h want %h", bus.tx_data, 8'hD2); else passed++;
        sender_frame(1);
    endtask

    task automatic test_timeout;
        int first_k;
        int pulses;
        bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h77};
        bus.req_valid = 4'b0001;
        @(negedge CLK);
        // START cycle: tx_start high here
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.tx_start !== 1'b1) $display("FAIL timeout_start: got %b want %b", bus.tx_start, 1'b1); else passed++;
        first_k = -1;
        pulses  = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            #1;
            if (bus.timeout_err === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        total++; if (first_k !== 17) $display("FAIL timeout_cycle: got %0d want %0d", first_k, 17); else passed++;
        total++; if (pulses !== 1) $display("FAIL timeout_pulse_len: got %0d want %0d", pulses, 1); else passed++;
        // back in IDLE: pointer is at 1, requester 2 alone is granted
        bus.req_data  = {8'h00, 8'h33, 8'h00, 8'h00};
        bus.req_valid = 4'b0100;
        #1;
        total++; if (bus.req_ready !== 4'b0100) $display("FAIL timeout_regrant: got %b want %b", bus.req_ready, 4'b0100); else passed++;
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.tx_data !== 8'h33) $display("FAIL timeout_regrant_data: got %h want %h", bus.tx_data, 8'h33); else passed++;
        sender_frame(1);
    endtask

    task automatic test_reset_mid_frame;
        bus.req_data  = {8'h99, 8'h00, 8'h00, 8'h00};
        bus.req_valid = 4'b1000;
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        @(negedge CLK);
        bus.tx_busy = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        // in WAIT_DONE with a frame in flight
        RST_N = 1'b0;
        #1;
        total++; if (bus.tx_data !== 8'h00) $display("FAIL rst_mid_data: got %h want %h", bus.tx_data, 8'h00); else passed++;
        total++; if (bus.grant_id !== 2'd0) $display("FAIL rst_mid_grant_id: got %0d want %0d", bus.grant_id, 0); else passed++;
        total++; if (bus.tx_start !== 1'b0) $display("FAIL rst_mid_start: got %b want %b", bus.tx_start, 1'b0); else passed++;
        @(negedge CLK);
        RST_N = 1'b1;
        bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h61};
        bus.req_valid = 4'b0001;
        repeat (3) @(negedge CLK);
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL rst_mid_blocked: got %b want %b", bus.req_ready, 4'b0000); else passed++;
        @(negedge CLK);
        bus.tx_busy = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0001) $display("FAIL rst_mid_release: got %b want %b", bus.req_ready, 4'b0001); else passed++;
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.tx_data !== 8'h61) $display("FAIL rst_mid_data_after: got %h want %h", bus.tx_data, 8'h61); else passed++;
        sender_frame(1);
    endtask

    task automatic test_pre_busy;
        RST_N         = 1'b0;
        bus.tx_busy   = 1'b1;
        bus.req_data  = {8'hC3, 8'h00, 8'h00, 8'h00};
        bus.req_valid = 4'b1000;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL prebusy_ready_0: got %b want %b", bus.req_ready, 4'b0000); else passed++;
        repeat (3) @(negedge CLK);
        #1;
        total++; if (bus.req_ready !== 4'b0000) $display("FAIL prebusy_ready_3: got %b want %b", bus.req_ready, 4'b0000); else passed++;
        @(negedge CLK);
        bus.tx_busy = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b1000) $display("FAIL prebusy_grant: got %b want %b", bus.req_ready, 4'b1000); else passed++;
        @(negedge CLK);
        bus.req_valid = 4'b0000;
        #1;
        total++; if (bus.tx_start !== 1'b1) $display("FAIL prebusy_start: got %b want %b", bus.tx_start, 1'b1); else passed++;
        total++; if (bus.grant_id !== 2'd3) $display("FAIL prebusy_grant_id: got %0d want %0d", bus.grant_id, 3); else passed++;
        total++; if (bus.tx_data !== 8'hC3) $display("FAIL prebusy_data: got %h want %h", bus.tx_data, 8'hC3); else passed++;
        sender_frame(1);
    endtask

    initial begin
        passed        = 0;
        total         = 0;
        RST_N         = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_data  = 32'h0000_0000;
        bus.tx_busy   = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_wrap();
        test_timeout();
        test_reset_mid_frame();
        test_pre_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Overall time bound in case the design wedges the sequence.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule
